// File: rtl/min_max_tracker_32_bit_if.sv
// Sample-in / result-out bundle for the min/max tracker.
// The tracker uses the slave side; the producer/consumer uses the master side.
interface min_max_tracker_32_bit_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
);
   logic [DATA_WIDTH-1:0]  Data_In;
   logic                   Data_Valid_In;
   logic                   Data_Last_In;
   logic                   Data_Ready_Out;
   logic [DATA_WIDTH-1:0]  Min_Out;
   logic [DATA_WIDTH-1:0]  Max_Out;
   logic [COUNT_WIDTH-1:0] Count_Out;
   logic                   Overflow_Out;
   logic                   Result_Valid_Out;
   logic                   Result_Ready_In;

   modport slave (
      input  Data_In, Data_Valid_In, Data_Last_In, Result_Ready_In,
      output Data_Ready_Out, Min_Out, Max_Out, Count_Out, Overflow_Out, Result_Valid_Out
   );

   modport master (
      output Data_In, Data_Valid_In, Data_Last_In, Result_Ready_In,
      input  Data_Ready_Out, Min_Out, Max_Out, Count_Out, Overflow_Out, Result_Valid_Out
   );
endinterface

// File: rtl/min_max_tracker_32_bit.sv
// Per-frame running min/max/count of a sample stream, result held under valid/ready.
// Define MIN_MAX_SIGNED_EN for two's-complement comparison; unsigned otherwise.
module min_max_tracker_32_bit #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic Clock_In,
   input  logic Reset_In,
   input  logic Enable_In,
   min_max_tracker_32_bit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  minVal_q, minVal_d;
   logic [DATA_WIDTH-1:0]  maxVal_q, maxVal_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   overflow_q, overflow_d;

   logic dataReady;
   logic sampleAccept;
   logic belowMin;
   logic aboveMax;
   logic countFull;

   assign dataReady    = Enable_In && (state_q != HOLD);
   assign sampleAccept = bus.Data_Valid_In && dataReady;
   assign countFull    = (count_q == COUNT_MAX);

`ifdef MIN_MAX_SIGNED_EN
   assign belowMin = $signed(bus.Data_In) < $signed(minVal_q);
   assign aboveMax = $signed(bus.Data_In) > $signed(maxVal_q);
`else
   assign belowMin = bus.Data_In < minVal_q;
   assign aboveMax = bus.Data_In > maxVal_q;
`endif

   // Next-state: the first beat seeds the statistics, later beats refine them.
   always_comb begin
      state_d    = state_q;
      minVal_d   = minVal_q;
      maxVal_d   = maxVal_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE: begin
            if (sampleAccept) begin
               minVal_d   = bus.Data_In;
               maxVal_d   = bus.Data_In;
               count_d    = COUNT_ONE;
               overflow_d = 1'b0;
               state_d    = bus.Data_Last_In ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (sampleAccept) begin
               if (belowMin) minVal_d = bus.Data_In;
               if (aboveMax) maxVal_d = bus.Data_In;
               if (countFull) overflow_d = 1'b1;
               else           count_d    = count_q + COUNT_ONE;
               if (bus.Data_Last_In) state_d = HOLD;
            end
         end
         HOLD: begin
            // Draining ignores Enable_In so a stalled upstream never blocks the consumer.
            if (bus.Result_Ready_In) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         state_q    <= IDLE;
         minVal_q   <= '0;
         maxVal_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         minVal_q   <= minVal_d;
         maxVal_q   <= maxVal_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.Data_Ready_Out   = dataReady;
   assign bus.Min_Out          = minVal_q;
   assign bus.Max_Out          = maxVal_q;
   assign bus.Count_Out        = count_q;
   assign bus.Overflow_Out     = overflow_q;
   assign bus.Result_Valid_Out = (state_q == HOLD);

endmodule

// File: tb/tb_min_max_tracker_32_bit.sv
// Bench for min_max_tracker_32_bit: two instances (16-bit and 4-bit counters) share one
// stimulus stream and are checked every cycle against a frame-queue reference model.
module tb_min_max_tracker_32_bit;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] sampleData;
   logic        sampleValid;
   logic        sampleLast;
   logic        resultReady;

   int checks = 0;
   int errors = 0;

   // Reference model: samples of the open frame plus the result of the last closed frame.
   logic [31:0] frameQ[$];
   logic        mHolding = 1'b0;
   logic        mCleared = 1'b1;
   logic [31:0] mMin = '0;
   logic [31:0] mMax = '0;
   int          mCount = 0;
   logic [31:0] prevData = '0;

   always #5 clock = ~clock;

   min_max_tracker_32_bit_if #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) bus16 ();
   min_max_tracker_32_bit_if #(.DATA_WIDTH(32), .COUNT_WIDTH(4))  bus4 ();

   assign bus16.Data_In         = sampleData;
   assign bus16.Data_Valid_In   = sampleValid;
   assign bus16.Data_Last_In    = sampleLast;
   assign bus16.Result_Ready_In = resultReady;
   assign bus4.Data_In          = sampleData;
   assign bus4.Data_Valid_In    = sampleValid;
   assign bus4.Data_Last_In     = sampleLast;
   assign bus4.Result_Ready_In  = resultReady;

   min_max_tracker_32_bit #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut16 (
      .Clock_In  (clock),
      .Reset_In  (reset),
      .Enable_In (enable),
      .bus       (bus16.slave)
   );

   min_max_tracker_32_bit #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut4 (
      .Clock_In  (clock),
      .Reset_In  (reset),
      .Enable_In (enable),
      .bus       (bus4.slave)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   function automatic logic isLess(input logic [31:0] a, input logic [31:0] b);
`ifdef MIN_MAX_SIGNED_EN
      return $signed(a) < $signed(b);
`else
      return a < b;
`endif
   endfunction

   function automatic int satCount(input int n, input int width);
      int limit;
      limit = (1 << width) - 1;
      return (n > limit) ? limit : n;
   endfunction

   task automatic closeFrame();
      mMin = frameQ[0];
      mMax = frameQ[0];
      foreach (frameQ[i]) begin
         if (isLess(frameQ[i], mMin)) mMin = frameQ[i];
         if (isLess(mMax, frameQ[i])) mMax = frameQ[i];
      end
      mCount = frameQ.size();
   endtask

   // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
   always @(negedge clock) begin
      checkOutput("ready16", bus16.Data_Ready_Out, enable && !mHolding);
      checkOutput("ready4", bus4.Data_Ready_Out, enable && !mHolding);
      checkOutput("valid16", bus16.Result_Valid_Out, mHolding);
      checkOutput("valid4", bus4.Result_Valid_Out, mHolding);
      if (mHolding) begin
         checkOutput("min16", bus16.Min_Out, mMin);
         checkOutput("max16", bus16.Max_Out, mMax);
         checkOutput("count16", bus16.Count_Out, satCount(mCount, 16));
         checkOutput("ovf16", bus16.Overflow_Out, mCount > 65535);
         checkOutput("min4", bus4.Min_Out, mMin);
         checkOutput("max4", bus4.Max_Out, mMax);
         checkOutput("count4", bus4.Count_Out, satCount(mCount, 4));
         checkOutput("ovf4", bus4.Overflow_Out, mCount > 15);
      end else if (mCleared) begin
         checkOutput("rstMin16", bus16.Min_Out, 0);
         checkOutput("rstMax16", bus16.Max_Out, 0);
         checkOutput("rstCount16", bus16.Count_Out, 0);
         checkOutput("rstOvf16", bus16.Overflow_Out, 0);
         checkOutput("rstCount4", bus4.Count_Out, 0);
      end
      if (reset) begin
         frameQ.delete();
         mHolding = 1'b0;
         mCleared = 1'b1;
      end else if (mHolding) begin
         if (resultReady) mHolding = 1'b0;
      end else if (enable && sampleValid) begin
         frameQ.push_back(sampleData);
         mCleared = 1'b0;
         if (sampleLast) begin
            closeFrame();
            mHolding = 1'b1;
            frameQ.delete();
         end
      end
   end

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] d, input logic v, input logic l);
      sampleData  = d;
      sampleValid = v;
      sampleLast  = l;
   endtask

   task automatic sendBeat(input logic [31:0] d, input logic last);
      logic rdy;
      bit   done;
      done = 1'b0;
      rdy  = 1'b0;
      applyStimulus(d, 1'b1, last);
      for (int k = 0; k < 100 && !done; k++) begin
         #1 rdy = bus16.Data_Ready_Out;
         @(posedge clock);
         #1;
         if (rdy) done = 1'b1;
      end
      if (!done) checkOutput("beatTimeout", rdy, 1);
      applyStimulus($urandom, 1'b0, 1'b0);
      prevData = d;
   endtask

   task automatic drainResult();
      logic v;
      bit   done;
      done = 1'b0;
      v    = 1'b0;
      resultReady = 1'b1;
      for (int k = 0; k < 100 && !done; k++) begin
         #1 v = bus16.Result_Valid_Out;
         @(posedge clock);
         #1;
         if (v) done = 1'b1;
      end
      resultReady = 1'b0;
      if (!done) checkOutput("drainTimeout", v, 1);
      checkOutput("drainValidLow", bus16.Result_Valid_Out, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] watchdog expired before the bench completed");
      $fatal(1, "[TB] time limit reached");
   end

   initial begin
      logic [31:0] d;
      int          len;

      reset       = 1'b1;
      enable      = 1'b0;
      resultReady = 1'b0;
      applyStimulus('0, 1'b0, 1'b0);

      // Reset for two cycles with enable low, then release.
      repeat (2) stepCycle();
      checkOutput("t1Ready", bus16.Data_Ready_Out, 0);
      checkOutput("t1Valid", bus16.Result_Valid_Out, 0);
      checkOutput("t1Min", bus16.Min_Out, 0);
      checkOutput("t1Count", bus16.Count_Out, 0);
      reset  = 1'b0;
      enable = 1'b1;
      #1 checkOutput("t1ReadyEn", bus16.Data_Ready_Out, 1);
      stepCycle();

      // Basic frame.
      sendBeat(32'd5, 1'b0);
      sendBeat(32'd3, 1'b0);
      sendBeat(32'd9, 1'b0);
      checkOutput("t2ValidBefore", bus16.Result_Valid_Out, 0);
      sendBeat(32'd3, 1'b1);
      checkOutput("t2ValidRise", bus16.Result_Valid_Out, 1);
      checkOutput("t2Min", bus16.Min_Out, 3);
      checkOutput("t2Max", bus16.Max_Out, 9);
      checkOutput("t2Count", bus16.Count_Out, 4);
      checkOutput("t2Ovf", bus16.Overflow_Out, 0);
      drainResult();

      // Single-sample frame held while the consumer is not ready.
      sendBeat(32'hFFFF_FFFF, 1'b1);
      repeat (10) begin
         stepCycle();
         checkOutput("t3Min", bus16.Min_Out, 32'hFFFF_FFFF);
         checkOutput("t3Max", bus16.Max_Out, 32'hFFFF_FFFF);
         checkOutput("t3Count", bus16.Count_Out, 1);
         checkOutput("t3Valid", bus16.Result_Valid_Out, 1);
         checkOutput("t3Ready", bus16.Data_Ready_Out, 0);
      end
      drainResult();

      // Sign boundary.
      sendBeat(32'h7FFF_FFFF, 1'b0);
      sendBeat(32'h8000_0000, 1'b1);
`ifdef MIN_MAX_SIGNED_EN
      checkOutput("t4Min", bus16.Min_Out, 32'h8000_0000);
      checkOutput("t4Max", bus16.Max_Out, 32'h7FFF_FFFF);
`else
      checkOutput("t4Min", bus16.Min_Out, 32'h7FFF_FFFF);
      checkOutput("t4Max", bus16.Max_Out, 32'h8000_0000);
`endif
      drainResult();

      // Counter saturation on the 4-bit instance, then a fresh short frame.
      for (int i = 0; i < 20; i++) sendBeat(32'(100 + i), i == 19);
      checkOutput("t5Count4", bus4.Count_Out, 15);
      checkOutput("t5Ovf4", bus4.Overflow_Out, 1);
      checkOutput("t5Count16", bus16.Count_Out, 20);
      checkOutput("t5Ovf16", bus16.Overflow_Out, 0);
      checkOutput("t5Max4", bus4.Max_Out, 119);
      drainResult();
      sendBeat(32'd4, 1'b0);
      sendBeat(32'd6, 1'b1);
      checkOutput("t5bCount4", bus4.Count_Out, 2);
      checkOutput("t5bOvf4", bus4.Overflow_Out, 0);
      drainResult();

      // Enable stall with a sample offered: nothing is accepted.
      sendBeat(32'd50, 1'b0);
      sendBeat(32'd40, 1'b0);
      enable = 1'b0;
      applyStimulus(32'd0, 1'b1, 1'b0);
      repeat (3) stepCycle();
      applyStimulus(32'd0, 1'b0, 1'b0);
      enable = 1'b1;
      sendBeat(32'd60, 1'b1);
      checkOutput("t6Min", bus16.Min_Out, 40);
      checkOutput("t6Max", bus16.Max_Out, 60);
      checkOutput("t6Count", bus16.Count_Out, 3);
      drainResult();

      // Reset pulse mid-frame discards the partial frame.
      sendBeat(32'd7, 1'b0);
      sendBeat(32'd8, 1'b0);
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      checkOutput("t6RstMin", bus16.Min_Out, 0);
      checkOutput("t6RstMax", bus16.Max_Out, 0);
      checkOutput("t6RstCount", bus16.Count_Out, 0);
      checkOutput("t6RstValid", bus16.Result_Valid_Out, 0);
      sendBeat(32'd1, 1'b0);
      sendBeat(32'd2, 1'b1);
      checkOutput("t6bMin", bus16.Min_Out, 1);
      checkOutput("t6bMax", bus16.Max_Out, 2);
      checkOutput("t6bCount", bus16.Count_Out, 2);
      drainResult();

      // Randomized frames with stalls, gaps, extreme values and repeated values.
      for (int f = 0; f < 40; f++) begin
         len = ($urandom_range(0, 4) == 0) ? $urandom_range(18, 26) : $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 5) == 0) begin
               enable = 1'b0;
               repeat ($urandom_range(1, 3)) stepCycle();
               enable = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) stepCycle();
            case ($urandom_range(0, 7))
               0:       d = 32'h0000_0000;
               1:       d = 32'hFFFF_FFFF;
               2:       d = 32'h7FFF_FFFF;
               3:       d = 32'h8000_0000;
               4:       d = prevData;
               default: d = $urandom;
            endcase
            sendBeat(d, i == len - 1);
         end
         repeat ($urandom_range(0, 3)) stepCycle();
         if ($urandom_range(0, 2) == 0) enable = 1'b0;
         drainResult();
         enable = 1'b1;
      end

      repeat (2) stepCycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
